// File: rtl/cla_bist_pkg.sv
// Shared types and constants for the CLA adder self-test engine.
// Holds the FSM state encoding, default operand width and vector-count helper.
`default_nettype none

package cla_bist_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  // Number of operand pairs in a full sweep of two n-bit operands.
  function automatic longint vec_count(input int n);
    return longint'(1) << (2 * n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_bist_if.sv
// Operand/sum bundle between the self-test engine (master) and the adder under test (slave).
// Widths follow the operand width N of the engine it is bound to.
`default_nettype none

interface cla_bist_if #(
  parameter int N = cla_bist_pkg::DEFAULT_N
);
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N:0]   dut_sum;

  modport master (output op_a, output op_b, input  dut_sum);
  modport slave  (input  op_a, input  op_b, output dut_sum);
endinterface

`default_nettype wire

// File: rtl/cla_bist_vecgen.sv
// Signed operand-pair generator: B is the inner counter, A the outer one.
// Stops on the last pair (both at the most positive value) and flags it.
`default_nettype none

module cla_bist_vecgen
  import cla_bist_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         step,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  output logic         last_vec
);

  localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] ONE_V = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] op_a_q, op_a_d;
  logic [N-1:0] op_b_q, op_b_d;

  assign last_vec = (op_a_q == MAX_V) && (op_b_q == MAX_V);

  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    if (clr) begin
      op_a_d = MIN_V;
      op_b_d = MIN_V;
    end else if (step && !last_vec) begin
      if (op_b_q == MAX_V) begin
        op_b_d = MIN_V;
        op_a_d = op_a_q + ONE_V;
      end else begin
        op_b_d = op_b_q + ONE_V;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q <= MIN_V;
      op_b_q <= MIN_V;
    end else begin
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
    end
  end

  assign op_a = op_a_q;
  assign op_b = op_b_q;

endmodule

`default_nettype wire

// File: rtl/cla_bist_engine.sv
// Self-test driver/checker for an N-bit signed adder: sweeps all operand pairs and counts bad sums.
// Optional macro CLA_BIST_CAPTURE_EN adds first-mismatch capture outputs first_a/first_b/first_sum.
`default_nettype none

module cla_bist_engine
  import cla_bist_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 2 * N + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  cla_bist_if.master       adder,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef CLA_BIST_CAPTURE_EN
  ,
  output logic [N-1:0]     first_a,
  output logic [N-1:0]     first_b,
  output logic [N:0]       first_sum
`endif
);

  localparam int               SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [SET_W-1:0] SET_ONE     = SET_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

  bist_state_t      state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic         vec_clr;
  logic         vec_step;
  logic         last_vec;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N:0]   ref_sum;
  logic         mismatch;

  cla_bist_vecgen #(.N(N)) u_vecgen (
    .clk      (clk),
    .rst      (rst),
    .clr      (vec_clr),
    .step     (vec_step),
    .op_a     (op_a),
    .op_b     (op_b),
    .last_vec (last_vec)
  );

  assign adder.op_a = op_a;
  assign adder.op_b = op_b;

  // Sign-extending both operands by one bit makes the reference sum overflow-free.
  assign ref_sum  = {op_a[N-1], op_a} + {op_b[N-1], op_b};
  assign mismatch = (adder.dut_sum != ref_sum);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    err_d    = err_q;
    vec_clr  = 1'b0;
    vec_step = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = DRIVE;
          settle_d = '0;
          err_d    = '0;
          vec_clr  = 1'b1;
        end
      end
      DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = CHECK;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SET_ONE;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + ERR_ONE;
        end
        vec_step = 1'b1;
        state_d  = last_vec ? DONE : DRIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      err_q    <= err_d;
    end
  end

  assign busy    = (state_q == DRIVE) || (state_q == CHECK);
  assign done    = (state_q == DONE);
  assign pass    = done && (err_q == '0);
  assign err_cnt = err_q;

`ifdef CLA_BIST_CAPTURE_EN
  logic         cap_hit_q, cap_hit_d;
  logic [N-1:0] first_a_q, first_a_d;
  logic [N-1:0] first_b_q, first_b_d;
  logic [N:0]   first_sum_q, first_sum_d;

  // Only the first bad vector of a sweep is kept; the hit flag blocks later overwrites.
  always_comb begin
    cap_hit_d   = cap_hit_q;
    first_a_d   = first_a_q;
    first_b_d   = first_b_q;
    first_sum_d = first_sum_q;
    if (vec_clr) begin
      cap_hit_d   = 1'b0;
      first_a_d   = '0;
      first_b_d   = '0;
      first_sum_d = '0;
    end else if ((state_q == CHECK) && mismatch && !cap_hit_q) begin
      cap_hit_d   = 1'b1;
      first_a_d   = op_a;
      first_b_d   = op_b;
      first_sum_d = adder.dut_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_hit_q   <= 1'b0;
      first_a_q   <= '0;
      first_b_q   <= '0;
      first_sum_q <= '0;
    end else begin
      cap_hit_q   <= cap_hit_d;
      first_a_q   <= first_a_d;
      first_b_q   <= first_b_d;
      first_sum_q <= first_sum_d;
    end
  end

  assign first_a   = first_a_q;
  assign first_b   = first_b_q;
  assign first_sum = first_sum_q;
`endif

endmodule

`default_nettype wire
